// File: rtl/prog_adrdecs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : prog_adrdecs                                                     |
// | Brief   : Runtime-programmable N-region physical address decoder with     |
// |           R/W/X and size permissions, registered one-hot lookup result.   |
// |           Optional entry lock via PROG_ADRDEC_LOCK_EN.                     |
// | Revision: 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module prog_adrdecs #(
  parameter int               PA_BITS    = 34,
  parameter int               NREGIONS   = 12,
  parameter logic [PA_BITS-1:0] BOOT_BASE  = 'h1000,
  parameter logic [PA_BITS-1:0] BOOT_RANGE = 'hFFF,
  parameter logic [8:0]       BOOT_ATTR  = 9'b0_1111_1011,
  localparam int              IW         = $clog2(NREGIONS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                CfgWe,
  input  logic [IW-1:0]       CfgIdx,
  input  logic [1:0]          CfgSel,
  input  logic [PA_BITS-1:0]  CfgWData,
  output logic                CfgErr,
  input  logic                ReqValid,
  input  logic [PA_BITS-1:0]  PhysicalAddress,
  input  logic                AccessR,
  input  logic                AccessW,
  input  logic                AccessX,
  input  logic [1:0]          Size,
  output logic                RspValid,
  output logic [NREGIONS:0]   SelRegions,
  output logic                Unmapped,
  output logic                AccessFault
);

  localparam logic [1:0] C_SEL_BASE  = 2'd0;
  localparam logic [1:0] C_SEL_RANGE = 2'd1;
  localparam logic [1:0] C_SEL_ATTR  = 2'd2;
  localparam logic [1:0] C_SEL_RSVD  = 2'd3;

  // Attr bits [7:0]: valid, R, W, X, size mask[3:0]; lock kept separately.
  logic [PA_BITS-1:0]  r_base  [NREGIONS];
  logic [PA_BITS-1:0]  r_range [NREGIONS];
  logic [7:0]          r_attr  [NREGIONS];

  logic [NREGIONS-1:0] w_idx_hit;
  logic [NREGIONS-1:0] w_match;
  logic [NREGIONS-1:0] w_pass;
  logic [NREGIONS:0]   w_sel;
  logic                w_cfg_bad;
  logic                w_locked;
  logic                w_wr_ok;
  logic                w_any_pass;

  logic                r_cfg_err;
  logic                r_rsp_valid;
  logic [NREGIONS:0]   r_sel;
  logic                r_unmapped;

  assign w_cfg_bad = ({1'b0, CfgIdx} >= (IW+1)'(NREGIONS)) || (CfgSel == C_SEL_RSVD);

`ifdef PROG_ADRDEC_LOCK_EN
  logic [NREGIONS-1:0] r_lock;

  assign w_locked = |(w_idx_hit & r_lock);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock    <= '0;
      r_lock[0] <= BOOT_ATTR[8];
    end else if (w_wr_ok) begin
      for (int i = 0; i < NREGIONS; i++) begin
        if (w_idx_hit[i] && CfgSel == C_SEL_ATTR) r_lock[i] <= CfgWData[8];
      end
    end
  end
`else
  assign w_locked = 1'b0;
`endif

  assign w_wr_ok = CfgWe & ~w_cfg_bad & ~w_locked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGIONS; i++) begin
        r_base[i]  <= (i == 0) ? BOOT_BASE       : '0;
        r_range[i] <= (i == 0) ? BOOT_RANGE      : '0;
        r_attr[i]  <= (i == 0) ? BOOT_ATTR[7:0]  : '0;
      end
    end else if (w_wr_ok) begin
      for (int i = 0; i < NREGIONS; i++) begin
        if (w_idx_hit[i]) begin
          case (CfgSel)
            C_SEL_BASE:  r_base[i]  <= CfgWData;
            C_SEL_RANGE: r_range[i] <= CfgWData;
            C_SEL_ATTR:  r_attr[i]  <= CfgWData[7:0];
            default:     ;
          endcase
        end
      end
    end
  end

  for (genvar g = 0; g < NREGIONS; g++) begin : g_entry
    logic [3:0] w_smask;
    assign w_idx_hit[g] = (CfgIdx == IW'(g));
    assign w_smask      = r_attr[g][7:4];
    assign w_match[g]   = r_attr[g][0] &
                          ((PhysicalAddress & ~r_range[g]) == (r_base[g] & ~r_range[g]));
    assign w_pass[g]    = w_match[g] & (~AccessR | r_attr[g][1]) & (~AccessW | r_attr[g][2]) &
                          (~AccessX | r_attr[g][3]) & w_smask[Size];
  end

  // Lowest passing entry wins; bit 0 flags "nothing passed".
  always_comb begin
    w_sel      = '0;
    w_any_pass = 1'b0;
    for (int i = 0; i < NREGIONS; i++) begin
      if (w_pass[i] && !w_any_pass) begin
        w_sel[i+1] = 1'b1;
        w_any_pass = 1'b1;
      end
    end
    if (!w_any_pass) w_sel[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cfg_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_sel       <= (NREGIONS+1)'(1);
      r_unmapped  <= 1'b0;
    end else begin
      r_cfg_err   <= CfgWe & (w_cfg_bad | w_locked);
      r_rsp_valid <= ReqValid;
      if (ReqValid) begin
        r_sel      <= w_sel;
        r_unmapped <= ~|w_match;
      end
    end
  end

  assign CfgErr      = r_cfg_err;
  assign RspValid    = r_rsp_valid;
  assign SelRegions  = r_sel;
  assign Unmapped    = r_unmapped;
  assign AccessFault = r_rsp_valid & r_sel[0];

endmodule
`default_nettype wire
